// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared types and encodings for the writeback stage
package writeback_stage_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LATCHED   = 2'd1,
    COMMITTED = 2'd2
  } wb_state_t;

  // data_size[1:0] is log2 of the access width in bytes
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;
  localparam int UNSIGNED_BIT = 2;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/writeback_stage_load_data_aligner.sv
// rtl/writeback_stage_load_data_aligner.sv - combinational load shift, truncate and extend
module load_data_aligner
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] loaded_data_in,
  input  logic [2:0]      offset,
  input  logic [2:0]      data_size,
  output logic [XLEN-1:0] load_result
);

  logic [XLEN-1:0] shifted;
  logic            sign_fill;

  // Logical shift leaves bytes beyond the doubleword as zero for crossing accesses.
  always_comb begin
    shifted     = loaded_data_in >> {offset, 3'b000};
    sign_fill   = 1'b0;
    load_result = shifted;
    case (data_size[1:0])
      SIZE_B: begin
        sign_fill   = ~data_size[UNSIGNED_BIT] & shifted[7];
        load_result = {{(XLEN-8){sign_fill}}, shifted[7:0]};
      end
      SIZE_H: begin
        sign_fill   = ~data_size[UNSIGNED_BIT] & shifted[15];
        load_result = {{(XLEN-16){sign_fill}}, shifted[15:0]};
      end
      SIZE_W: begin
        sign_fill   = ~data_size[UNSIGNED_BIT] & shifted[31];
        load_result = {{(XLEN-32){sign_fill}}, shifted[31:0]};
      end
      default: load_result = shifted;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - final pipeline stage: capture, align, commit to register file
// Optional forwarding ports are compiled in with WB_BYPASS_EN.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memory_done,
  input  logic [XLEN-1:0]       loaded_data_in,
  input  logic [XLEN-1:0]       alu_data,
  input  logic [XLEN-1:0]       pc_plus_4,
  input  logic                  is_load,
  input  logic                  jump_link,
  input  logic [2:0]            data_size,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic                  regfile_write_ready,
  output logic                  mem_wb_pipeline_valid,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]       rf_write_data,
`ifdef WB_BYPASS_EN
  output logic                  bypass_valid,
  output logic [REG_ADDR_W-1:0] bypass_reg,
  output logic [XLEN-1:0]       bypass_data,
`endif
  output logic                  writeback_done
);

  wb_state_t state, state_next;

  logic [XLEN-1:0]       cap_loaded;
  logic [XLEN-1:0]       cap_alu;
  logic [XLEN-1:0]       cap_pc;
  logic                  cap_is_load;
  logic                  cap_jump_link;
  logic [2:0]            cap_size;
  logic                  cap_reg_write;
  logic [REG_ADDR_W-1:0] cap_dest;

  logic            capture;
  logic            needs_write;
  logic [XLEN-1:0] load_result;
  logic [XLEN-1:0] result;

  assign capture     = (state == IDLE) && memory_done;
  assign needs_write = cap_reg_write && (cap_dest != REG_ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Captured fields reset to zero so the write port reads 0 while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_loaded    <= '0;
      cap_alu       <= '0;
      cap_pc        <= '0;
      cap_is_load   <= 1'b0;
      cap_jump_link <= 1'b0;
      cap_size      <= '0;
      cap_reg_write <= 1'b0;
      cap_dest      <= '0;
    end else if (capture) begin
      cap_loaded    <= loaded_data_in;
      cap_alu       <= alu_data;
      cap_pc        <= pc_plus_4;
      cap_is_load   <= is_load;
      cap_jump_link <= jump_link;
      cap_size      <= data_size;
      cap_reg_write <= reg_write;
      cap_dest      <= dest_reg;
    end
  end

  load_data_aligner #(
    .XLEN (XLEN)
  ) u_aligner (
    .loaded_data_in (cap_loaded),
    .offset         (cap_alu[2:0]),
    .data_size      (cap_size),
    .load_result    (load_result)
  );

  always_comb begin
    result = cap_alu;
    if (cap_is_load) begin
      result = load_result;
    end else if (cap_jump_link) begin
      result = cap_pc;
    end
  end

  always_comb begin
    state_next            = state;
    mem_wb_pipeline_valid = 1'b0;
    rf_write_enable       = 1'b0;
    writeback_done        = 1'b0;
    case (state)
      IDLE: begin
        if (memory_done) state_next = LATCHED;
      end
      LATCHED: begin
        mem_wb_pipeline_valid = 1'b1;
        rf_write_enable       = needs_write && regfile_write_ready;
        if (!needs_write || regfile_write_ready) begin
          writeback_done = 1'b1;
          state_next     = memory_done ? COMMITTED : IDLE;
        end
      end
      COMMITTED: begin
        mem_wb_pipeline_valid = 1'b1;
        if (!memory_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rf_write_addr = cap_dest;
  assign rf_write_data = result;

`ifdef WB_BYPASS_EN
  always_comb begin
    bypass_valid = mem_wb_pipeline_valid && needs_write && (state == LATCHED);
    bypass_reg   = bypass_valid ? cap_dest : '0;
    bypass_data  = bypass_valid ? result : '0;
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage, default build
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memory_done = 1'b0;
  logic [63:0] loaded_data_in = '0;
  logic [63:0] alu_data = '0;
  logic [63:0] pc_plus_4 = '0;
  logic        is_load = 1'b0;
  logic        jump_link = 1'b0;
  logic [2:0]  data_size = '0;
  logic        reg_write = 1'b0;
  logic [4:0]  dest_reg = '0;
  logic        regfile_write_ready = 1'b1;
  logic        mem_wb_pipeline_valid;
  logic        rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [63:0] rf_write_data;
  logic        writeback_done;

  int n_checks = 0;
  int n_fail = 0;
  int exp_done = 0;
  int seen_done = 0;
  logic [4:0]  exp_addr_q[$];
  logic [63:0] exp_data_q[$];

  writeback_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .memory_done           (memory_done),
    .loaded_data_in        (loaded_data_in),
    .alu_data              (alu_data),
    .pc_plus_4             (pc_plus_4),
    .is_load               (is_load),
    .jump_link             (jump_link),
    .data_size             (data_size),
    .reg_write             (reg_write),
    .dest_reg              (dest_reg),
    .regfile_write_ready   (regfile_write_ready),
    .mem_wb_pipeline_valid (mem_wb_pipeline_valid),
    .rf_write_enable       (rf_write_enable),
    .rf_write_addr         (rf_write_addr),
    .rf_write_data         (rf_write_data),
    .writeback_done        (writeback_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_instr(input logic ld, input logic jl, input logic [2:0] sz,
                           input logic [63:0] alu, input logic [63:0] ldat,
                           input logic [63:0] pc, input logic rw, input logic [4:0] rd);
    is_load = ld; jump_link = jl; data_size = sz; alu_data = alu;
    loaded_data_in = ldat; pc_plus_4 = pc; reg_write = rw; dest_reg = rd;
  endtask

  // One-shot instruction with a free write port; expected write pushed before capture.
  task automatic send(input string name, input logic ld, input logic jl, input logic [2:0] sz,
                      input logic [63:0] alu, input logic [63:0] ldat, input logic [63:0] pc,
                      input logic rw, input logic [4:0] rd, input logic exp_wr,
                      input logic [63:0] exp_val);
    @(posedge clk); #1;
    set_instr(ld, jl, sz, alu, ldat, pc, rw, rd);
    regfile_write_ready = 1'b1;
    memory_done = 1'b1;
    if (exp_wr) begin
      exp_addr_q.push_back(rd);
      exp_data_q.push_back(exp_val);
    end
    exp_done++;
    @(posedge clk); #1;
    memory_done = 1'b0;
    check({name, " valid"}, 64'(mem_wb_pipeline_valid), 64'd1);
    @(posedge clk); #1;
    check({name, " idle"}, 64'(mem_wb_pipeline_valid), 64'd0);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (writeback_done) seen_done++;
    if (rf_write_enable) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected write addr", 64'(rf_write_addr), 64'h1ff);
      end else begin
        check("write addr", 64'(rf_write_addr), 64'(exp_addr_q.pop_front()));
        check("write data", rf_write_data, exp_data_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", 64'(mem_wb_pipeline_valid), 64'd0);
    check("reset we", 64'(rf_write_enable), 64'd0);
    check("reset addr", 64'(rf_write_addr), 64'd0);
    check("reset data", rf_write_data, 64'd0);
    check("reset done", 64'(writeback_done), 64'd0);
    reset = 1'b1;

    send("lb", 1, 0, 3'b000, 64'h1003, 64'h00000000_80FF0000, 0, 1, 5'd5, 1, 64'hFFFFFFFF_FFFFFF80);
    send("lwu", 1, 0, 3'b110, 64'h2004, 64'hDEADBEEF_00000000, 0, 1, 5'd6, 1, 64'h00000000_DEADBEEF);
    send("lw", 1, 0, 3'b010, 64'h2004, 64'hDEADBEEF_00000000, 0, 1, 5'd7, 1, 64'hFFFFFFFF_DEADBEEF);
    send("lh cross", 1, 0, 3'b001, 64'h3007, 64'hAB00_0000_0000_0000, 0, 1, 5'd8, 1, 64'h00000000_000000AB);
    send("lh", 1, 0, 3'b001, 64'h3002, 64'h0000_0000_9234_0000, 0, 1, 5'd9, 1, 64'hFFFFFFFF_FFFF9234);
    send("lhu", 1, 0, 3'b101, 64'h3002, 64'h0000_0000_9234_0000, 0, 1, 5'd10, 1, 64'h00000000_00009234);
    send("lbu", 1, 0, 3'b100, 64'h3000, 64'h0000_0000_0000_0080, 0, 1, 5'd11, 1, 64'h00000000_00000080);
    send("ld", 1, 1, 3'b011, 64'h3000, 64'h8765_4321_0FED_CBA9, 64'h2004, 1, 5'd12, 1, 64'h8765_4321_0FED_CBA9);
    send("jal", 0, 1, 3'b011, 64'h5555, 0, 64'h2004, 1, 5'd1, 1, 64'h2004);
    send("alu", 0, 0, 3'b011, 64'h0123_4567_89AB_CDEF, 0, 64'h2004, 1, 5'd31, 1, 64'h0123_4567_89AB_CDEF);
    send("x0", 0, 1, 3'b011, 64'h77, 0, 64'h2004, 1, 5'd0, 0, 64'h0);
    send("no rw", 0, 0, 3'b011, 64'h99, 0, 0, 0, 5'd4, 0, 64'h0);

    // Write port busy for three cycles while memory_done stays high with new inputs.
    @(posedge clk); #1;
    set_instr(0, 0, 3'b011, 64'h1234_5678_9ABC_DEF0, 0, 0, 1, 5'd9);
    regfile_write_ready = 1'b0;
    memory_done = 1'b1;
    exp_addr_q.push_back(5'd9);
    exp_data_q.push_back(64'h1234_5678_9ABC_DEF0);
    exp_done++;
    @(posedge clk); #1;
    set_instr(0, 0, 3'b011, 64'h1111, 0, 0, 1, 5'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall valid", 64'(mem_wb_pipeline_valid), 64'd1);
      check("stall we", 64'(rf_write_enable), 64'd0);
      check("stall addr", 64'(rf_write_addr), 64'd9);
      check("stall data", rf_write_data, 64'h1234_5678_9ABC_DEF0);
      check("stall done", 64'(writeback_done), 64'd0);
    end
    @(posedge clk); #1;
    regfile_write_ready = 1'b1;
    @(posedge clk); #1;
    check("committed valid", 64'(mem_wb_pipeline_valid), 64'd1);
    check("committed we", 64'(rf_write_enable), 64'd0);
    check("committed done", 64'(writeback_done), 64'd0);
    memory_done = 1'b0;
    @(posedge clk); #1;
    check("post commit idle", 64'(mem_wb_pipeline_valid), 64'd0);

    // Reset in LATCHED discards the pending write.
    @(posedge clk); #1;
    set_instr(0, 0, 3'b011, 64'h55, 0, 0, 1, 5'd12);
    regfile_write_ready = 1'b0;
    memory_done = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    regfile_write_ready = 1'b1;
    set_instr(0, 0, 3'b011, 64'h66, 0, 0, 1, 5'd13);
    #1;
    check("mid reset valid", 64'(mem_wb_pipeline_valid), 64'd0);
    check("mid reset we", 64'(rf_write_enable), 64'd0);
    check("mid reset addr", 64'(rf_write_addr), 64'd0);
    check("mid reset data", rf_write_data, 64'd0);
    check("mid reset done", 64'(writeback_done), 64'd0);
    exp_addr_q.push_back(5'd13);
    exp_data_q.push_back(64'h66);
    exp_done++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post reset capture", 64'(mem_wb_pipeline_valid), 64'd1);
    memory_done = 1'b0;
    @(posedge clk); #1;
    check("post reset idle", 64'(mem_wb_pipeline_valid), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("writes outstanding", 64'(exp_addr_q.size()), 64'd0);
    check("done pulses", 64'(seen_done), 64'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
